// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: default sizes, FSM states
// and the nibble checksum helper.
package loader_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        GET_CNT,
        GET_FN,
        GET_DD,
        WRITE,
        GET_CHK,
        DONE,
        ERR
    } state_t;

    function automatic logic [DATA_W_DEF-1:0] chk_add(input logic [DATA_W_DEF-1:0] a,
                                                      input logic [DATA_W_DEF-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Fills the instruction memory from a COUNT/(FUNCAO,DADO)*/CHK nibble stream,
// holding the CPU idle while loading and reporting done/err when finished.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = 4,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_funcao,
    output logic [DATA_W-1:0] mem_dado,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // One extra bit so the word counter can hold DEPTH itself after the last word.
    localparam int CNT_W = ADDR_W + 1;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  addr_reg, addr_next;
    logic [DATA_W-1:0] sum_reg, sum_next;
    logic [DATA_W-1:0] fn_reg, fn_next;
    logic [ADDR_W-1:0] waddr_reg, waddr_next;
    logic [DATA_W-1:0] wfn_reg, wfn_next;
    logic [DATA_W-1:0] wdd_reg, wdd_next;
    logic              accept;

    assign in_ready = (state_reg == GET_CNT) || (state_reg == GET_FN) ||
                      (state_reg == GET_DD)  || (state_reg == GET_CHK);
    assign accept     = in_valid && in_ready;
    assign mem_we     = (state_reg == WRITE);
    assign cpu_hold   = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
    assign done       = (state_reg == DONE);
    assign err        = (state_reg == ERR);
    assign mem_addr   = waddr_reg;
    assign mem_funcao = wfn_reg;
    assign mem_dado   = wdd_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            sum_reg   <= '0;
            fn_reg    <= '0;
            waddr_reg <= '0;
            wfn_reg   <= '0;
            wdd_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            sum_reg   <= sum_next;
            fn_reg    <= fn_next;
            waddr_reg <= waddr_next;
            wfn_reg   <= wfn_next;
            wdd_reg   <= wdd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        sum_next   = sum_reg;
        fn_next    = fn_reg;
        waddr_next = waddr_reg;
        wfn_next   = wfn_reg;
        wdd_next   = wdd_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = GET_CNT;
                    sum_next   = '0;
                    addr_next  = '0;
                end
            end
            GET_CNT: begin
                if (accept) begin
                    sum_next  = in_data;
                    addr_next = '0;
                    if (in_data == '0) begin
                        cnt_next   = CNT_W'(DEPTH);
                        state_next = GET_FN;
                    end else if (int'(in_data) > DEPTH) begin
                        state_next = ERR;
                    end else begin
                        cnt_next   = CNT_W'(in_data);
                        state_next = GET_FN;
                    end
                end
            end
            GET_FN: begin
                if (accept) begin
                    fn_next    = in_data;
                    sum_next   = chk_add(sum_reg, in_data);
                    state_next = GET_DD;
                end
            end
            GET_DD: begin
                // The write port registers are loaded together so they change only with the strobe.
                if (accept) begin
                    sum_next   = chk_add(sum_reg, in_data);
                    waddr_next = addr_reg[ADDR_W-1:0];
                    wfn_next   = fn_reg;
                    wdd_next   = in_data;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                addr_next = addr_reg + CNT_W'(1);
                if (addr_reg + CNT_W'(1) == cnt_reg) begin
                    state_next = GET_CHK;
                end else begin
                    state_next = GET_FN;
                end
            end
            GET_CHK: begin
                if (accept) begin
                    if (chk_add(sum_reg, in_data) == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = ERR;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a DEPTH=16 and a DEPTH=8 instance,
// expected memory writes queued by stimulus and popped by a write monitor.
module tb_program_loader;

    logic            clk;
    logic            rst;
    logic [1:0]      start;
    logic [1:0]      in_valid;
    logic [1:0][3:0] in_data;
    logic [1:0]      in_ready;
    logic [1:0]      mem_we;
    logic [1:0][3:0] mem_addr;
    logic [1:0][3:0] mem_funcao;
    logic [1:0][3:0] mem_dado;
    logic [1:0]      cpu_hold;
    logic [1:0]      done;
    logic [1:0]      err;

    typedef struct {
        int       dut;
        logic [3:0] addr;
        logic [3:0] fn;
        logic [3:0] dd;
    } wr_t;

    wr_t expq[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_wr[2] = '{0, 0};

    program_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(4)) u16 (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]),
        .in_data(in_data[0]), .in_ready(in_ready[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_funcao(mem_funcao[0]), .mem_dado(mem_dado[0]),
        .cpu_hold(cpu_hold[0]), .done(done[0]), .err(err[0])
    );

    program_loader #(.DEPTH(8), .ADDR_W(3), .DATA_W(4)) u8 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]),
        .in_data(in_data[1]), .in_ready(in_ready[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1][2:0]), .mem_funcao(mem_funcao[1]), .mem_dado(mem_dado[1]),
        .cpu_hold(cpu_hold[1]), .done(done[1]), .err(err[1])
    );
    assign mem_addr[1][3] = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d] === 1'b1) begin
                n_wr[d]++;
                check($sformatf("in_ready_low_in_write_dut%0d", d), in_ready[d], 1'b0);
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write dut%0d: got addr %0d fn %0h dd %0h expected no write",
                             d, mem_addr[d], mem_funcao[d], mem_dado[d]);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    if (e.dut != d || mem_addr[d] !== e.addr || mem_funcao[d] !== e.fn ||
                        mem_dado[d] !== e.dd) begin
                        n_bad++;
                        $display("FAIL write dut%0d: got addr %0d fn %0h dd %0h expected dut%0d addr %0d fn %0h dd %0h",
                                 d, mem_addr[d], mem_funcao[d], mem_dado[d], e.dut, e.addr, e.fn, e.dd);
                    end else begin
                        $display("write dut%0d addr %0d fn %0h dd %0h ok", d, e.addr, e.fn, e.dd);
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [3:0] val, input bit bp);
        bit got;
        got = 1'b0;
        if (bp) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        in_data[d]  = val;
        in_valid[d] = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        in_valid[d] = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout dut%0d: got no in_ready expected accept of %0h", d, val);
        end
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        @(negedge clk);
        check($sformatf("start_in_ready_dut%0d", d), in_ready[d], 1'b1);
        check($sformatf("start_cpu_hold_dut%0d", d), cpu_hold[d], 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Streams COUNT, n pairs and CHK; queues the n expected writes when legal.
    task automatic load(input int d, input logic [3:0] cnt, input int n,
                        input logic [3:0] fns[16], input logic [3:0] dds[16],
                        input logic [3:0] chk, input bit bp,
                        input bit exp_done, input bit exp_err);
        int w0;
        w0 = n_wr[d];
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.dut = d; e.addr = 4'(i); e.fn = fns[i]; e.dd = dds[i];
            expq.push_back(e);
        end
        pulse_start(d);
        send(d, cnt, bp);
        for (int i = 0; i < n; i++) begin
            send(d, fns[i], bp);
            send(d, dds[i], bp);
        end
        if (!exp_err || n > 0) send(d, chk, bp);
        @(negedge clk);
        check($sformatf("done_dut%0d", d), done[d], exp_done);
        check($sformatf("err_dut%0d", d), err[d], exp_err);
        check($sformatf("cpu_hold_end_dut%0d", d), cpu_hold[d], 1'b0);
        check($sformatf("write_count_dut%0d", d), n_wr[d] - w0, n);
        check($sformatf("pending_writes_dut%0d", d), expq.size(), 0);
        $display("load dut%0d cnt %0d chk %0h done %0b err %0b", d, cnt, chk, done[d], err[d]);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] fa[16];
    logic [3:0] da[16];

    initial begin
        rst = 1'b1; start = '0; in_valid = '0; in_data = '0;
        for (int i = 0; i < 16; i++) begin fa[i] = '0; da[i] = '0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_in_ready", in_ready[d], 1'b0);
            check("reset_mem_we", mem_we[d], 1'b0);
            check("reset_mem_addr", mem_addr[d], 4'd0);
            check("reset_mem_funcao", mem_funcao[d], 4'd0);
            check("reset_mem_dado", mem_dado[d], 4'd0);
            check("reset_cpu_hold", cpu_hold[d], 1'b0);
            check("reset_done", done[d], 1'b0);
            check("reset_err", err[d], 1'b0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal: 2,(3,5),(1,7); sum 18 -> 2, CHK 14.
        fa[0] = 4'd3; da[0] = 4'd5; fa[1] = 4'd1; da[1] = 4'd7;
        load(0, 4'd2, 2, fa, da, 4'd14, 1'b0, 1'b1, 1'b0);
        // Bad checksum: same words still written.
        load(0, 4'd2, 2, fa, da, 4'd0, 1'b0, 1'b0, 1'b1);
        // Backpressure, same image.
        load(0, 4'd2, 2, fa, da, 4'd14, 1'b1, 1'b1, 1'b0);

        // COUNT=0 -> 16 words (i,~i); each pair sums to 15, total 240 -> 0, CHK 0.
        begin
            logic [3:0] f16[16];
            logic [3:0] d16[16];
            for (int i = 0; i < 16; i++) begin f16[i] = 4'(i); d16[i] = 4'(15 - i); end
            load(0, 4'd0, 16, f16, d16, 4'd0, 1'b0, 1'b1, 1'b0);
        end

        // DEPTH=8: COUNT=9 illegal -> err after one accept, no writes.
        load(1, 4'd9, 0, fa, da, 4'd0, 1'b0, 1'b0, 1'b1);
        load(1, 4'd2, 2, fa, da, 4'd14, 1'b0, 1'b1, 1'b0);
        // Boundary: COUNT=8 equals DEPTH; words (i,0) sum 8+28=36 -> 4, CHK 12.
        begin
            logic [3:0] f8[16];
            logic [3:0] d8[16];
            for (int i = 0; i < 16; i++) begin f8[i] = 4'(i); d8[i] = 4'd0; end
            load(1, 4'd8, 8, f8, d8, 4'd12, 1'b0, 1'b1, 1'b0);
        end

        // Reset after the first word is written.
        begin
            wr_t e;
            e.dut = 0; e.addr = 4'd0; e.fn = 4'd3; e.dd = 4'd5;
            expq.push_back(e);
        end
        pulse_start(0);
        send(0, 4'd2, 1'b0);
        send(0, 4'd3, 1'b0);
        send(0, 4'd5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midload_pending", expq.size(), 0);
        check("midload_in_ready", in_ready[0], 1'b0);
        check("midload_mem_we", mem_we[0], 1'b0);
        check("midload_mem_addr", mem_addr[0], 4'd0);
        check("midload_mem_funcao", mem_funcao[0], 4'd0);
        check("midload_mem_dado", mem_dado[0], 4'd0);
        check("midload_cpu_hold", cpu_hold[0], 1'b0);
        check("midload_done", done[0], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_idle_ready", in_ready[0], 1'b0);
        check("post_reset_idle_hold", cpu_hold[0], 1'b0);
        check("post_reset_err", err[0], 1'b0);
        @(posedge clk);
        #1;

        // start while busy must be ignored.
        for (int i = 0; i < 2; i++) begin
            wr_t e;
            e.dut = 0; e.addr = 4'(i); e.fn = fa[i]; e.dd = da[i];
            expq.push_back(e);
        end
        pulse_start(0);
        send(0, 4'd2, 1'b0);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        send(0, 4'd3, 1'b0);
        send(0, 4'd5, 1'b0);
        send(0, 4'd1, 1'b0);
        send(0, 4'd7, 1'b0);
        send(0, 4'd14, 1'b0);
        @(negedge clk);
        check("busy_start_done", done[0], 1'b1);
        check("busy_start_err", err[0], 1'b0);
        check("busy_start_pending", expq.size(), 0);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule
